// File: rtl/wb_reg_bank.sv
// Writeback-side 32x16 register bank with two registered read ports and a RAW scoreboard.
// Optional WB_REG_BANK_BYPASS_EN forwards same-cycle writeback data to reads and clears STALL early.
module wb_reg_bank #(
    parameter int WIDTH = 16,
    parameter int NREGS = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] WB_DATA_IN,
    input  logic [4:0]       WB_ADDR_IN,
    input  logic             WB_COND_IN,
    input  logic [4:0]       RD_ADDR_A,
    input  logic [4:0]       RD_ADDR_B,
    input  logic             RSV_EN,
    input  logic [4:0]       RSV_ADDR,
    output logic [WIDTH-1:0] DATA_A_OUT,
    output logic [WIDTH-1:0] DATA_B_OUT,
    output logic             STALL,
    output logic             READY,
    output logic [1:0]       ESTADO
);
    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       clr_cnt_q, clr_cnt_d;
    logic [NREGS-1:0] pend_q, pend_d, pend_next;
    logic [WIDTH-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
    logic             ready_q, ready_d;

    logic [WIDTH-1:0] mem [NREGS];
    logic             mem_we;
    logic [4:0]       mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

    logic             run, wr_valid, rsv_valid;
    logic             hit_a, hit_b, stall_a, stall_b;

    assign run       = (state_q == ST_RUN);
    assign wr_valid  = run && WB_COND_IN && (WB_ADDR_IN != 5'd0);
    assign rsv_valid = run && RSV_EN && (RSV_ADDR != 5'd0);

`ifdef WB_REG_BANK_BYPASS_EN
    assign hit_a = wr_valid && (WB_ADDR_IN == RD_ADDR_A);
    assign hit_b = wr_valid && (WB_ADDR_IN == RD_ADDR_B);
`else
    assign hit_a = 1'b0;
    assign hit_b = 1'b0;
`endif

    // Reserve is applied after the writeback clear so the newer instruction's claim wins.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_pend
            if (gi == 0) begin : g_zero
                assign pend_next[gi] = 1'b0;
            end else begin : g_bit
                assign pend_next[gi] = (rsv_valid && (RSV_ADDR == 5'(gi))) ||
                                       (pend_q[gi] && !(wr_valid && (WB_ADDR_IN == 5'(gi))));
            end
        end
    endgenerate

    assign stall_a = (RD_ADDR_A != 5'd0) && pend_q[RD_ADDR_A] && !hit_a;
    assign stall_b = (RD_ADDR_B != 5'd0) && pend_q[RD_ADDR_B] && !hit_b;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        pend_d    = '0;
        data_a_d  = '0;
        data_b_d  = '0;
        mem_we    = 1'b0;
        mem_waddr = WB_ADDR_IN;
        mem_wdata = WB_DATA_IN;
        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = '0;
                clr_cnt_d = clr_cnt_q + 5'd1;
                if (clr_cnt_q == 5'd31) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                mem_we   = wr_valid;
                pend_d   = pend_next;
                data_a_d = (RD_ADDR_A == 5'd0) ? '0 : (hit_a ? WB_DATA_IN : mem[RD_ADDR_A]);
                data_b_d = (RD_ADDR_B == 5'd0) ? '0 : (hit_b ? WB_DATA_IN : mem[RD_ADDR_B]);
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = 5'd0;
            end
        endcase
        if (RST) begin
            mem_we = 1'b0;
        end
        ready_d = (state_d == ST_RUN);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= 5'd0;
            pend_q    <= '0;
            data_a_q  <= '0;
            data_b_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            pend_q    <= pend_d;
            data_a_q  <= data_a_d;
            data_b_q  <= data_b_d;
            ready_q   <= ready_d;
        end
    end

    // Storage array kept reset-free so it maps onto RAM; the clear pass zeroes it.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign DATA_A_OUT = data_a_q;
    assign DATA_B_OUT = data_b_q;
    assign READY      = ready_q;
    assign ESTADO     = state_q;
    assign STALL      = !run || stall_a || stall_b;

endmodule

// File: tb/tb_wb_reg_bank.sv
// Directed self-checking bench for wb_reg_bank; expectations follow WB_REG_BANK_BYPASS_EN.
module tb_wb_reg_bank;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] wb_data;
    logic [4:0]  wb_addr;
    logic        wb_cond;
    logic [4:0]  addr_a, addr_b;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [15:0] data_a, data_b;
    logic        stall, ready;
    logic [1:0]  estado;

    int checks = 0;
    int errors = 0;

`ifdef WB_REG_BANK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    always #5 clk = ~clk;

    wb_reg_bank dut (
        .CLK(clk), .RST(rst),
        .WB_DATA_IN(wb_data), .WB_ADDR_IN(wb_addr), .WB_COND_IN(wb_cond),
        .RD_ADDR_A(addr_a), .RD_ADDR_B(addr_b),
        .RSV_EN(rsv_en), .RSV_ADDR(rsv_addr),
        .DATA_A_OUT(data_a), .DATA_B_OUT(data_b),
        .STALL(stall), .READY(ready), .ESTADO(estado)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_data = '0; wb_addr = '0; wb_cond = 1'b0;
        addr_a = '0; addr_b = '0; rsv_en = 1'b0; rsv_addr = '0;
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, got, exp);
        end else begin
            $display("ok   %s: 0x%04h", name, got);
        end
    endtask

    task automatic wait_clear();
        for (int i = 1; i <= 32; i++) begin
            step();
            if (i < 32) begin
                checks++;
                if (ready !== 1'b0 || estado !== 2'd0) begin
                    errors++;
                    $display("FAIL clear_edge%0d: ready=%b estado=%0d expected ready=0 estado=0", i, ready, estado);
                end
            end
        end
        chk("ready_after_32", 16'(ready), 16'd1);
        chk("estado_run", 16'(estado), 16'd1);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_estado", 16'(estado), 16'd0);
        chk("rst_ready", 16'(ready), 16'd0);
        chk("rst_data_a", data_a, 16'h0000);
        chk("rst_stall", 16'(stall), 16'd1);
        wait_clear();
        for (int i = 0; i < 32; i++) begin
            addr_a = 5'(i);
            addr_b = 5'(31 - i);
            step();
            checks++;
            if (data_a !== 16'h0 || data_b !== 16'h0) begin
                errors++;
                $display("FAIL clear_read%0d: a=0x%04h b=0x%04h expected 0", i, data_a, data_b);
            end
        end
        addr_a = '0; addr_b = '0;
    endtask

    task automatic test_write_read();
        wb_cond = 1'b1; wb_addr = 5'd5; wb_data = 16'h1234;
        step();
        wb_cond = 1'b0;
        addr_a = 5'd5; addr_b = 5'd0;
        step();
        chk("wr_r5_a", data_a, 16'h1234);
        chk("wr_r5_b_zero", data_b, 16'h0000);
        wb_cond = 1'b1; wb_addr = 5'd0; wb_data = 16'hFFFF;
        step();
        wb_cond = 1'b0;
        addr_a = 5'd0;
        step();
        chk("wr_r0_dropped", data_a, 16'h0000);
    endtask

    task automatic test_same_cycle();
        wb_cond = 1'b1; wb_addr = 5'd7; wb_data = 16'h1111;
        step();
        wb_data = 16'hBEEF; addr_a = 5'd7;
        step();
        wb_cond = 1'b0;
        chk("same_cycle_r7", data_a, BYP ? 16'hBEEF : 16'h1111);
        step();
        chk("next_read_r7", data_a, 16'hBEEF);
        addr_a = '0;
    endtask

    task automatic test_hazard();
        rsv_en = 1'b1; rsv_addr = 5'd3;
        step();
        rsv_en = 1'b0;
        addr_a = 5'd3;
        #1;
        chk("hz_stall_set", 16'(stall), 16'd1);
        wb_addr = 5'd3; wb_data = 16'h0042; wb_cond = 1'b0;
        #1;
        chk("hz_cond0_comb", 16'(stall), 16'd1);
        step();
        chk("hz_cond0_after", 16'(stall), 16'd1);
        wb_cond = 1'b1;
        #1;
        chk("hz_write_cycle", 16'(stall), BYP ? 16'd0 : 16'd1);
        step();
        wb_cond = 1'b0;
        #1;
        chk("hz_after_write", 16'(stall), 16'd0);
        chk("hz_data_capture", data_a, BYP ? 16'h0042 : 16'h0000);
        step();
        chk("hz_data_r3", data_a, 16'h0042);
        addr_a = '0;
    endtask

    task automatic test_rsv_wb_same();
        rsv_en = 1'b1; rsv_addr = 5'd9;
        wb_cond = 1'b1; wb_addr = 5'd9; wb_data = 16'h5555;
        step();
        rsv_en = 1'b0; wb_cond = 1'b0;
        addr_a = 5'd9; addr_b = 5'd0;
        #1;
        chk("rsvwb_stall_a", 16'(stall), 16'd1);
        addr_a = 5'd0; addr_b = 5'd9;
        #1;
        chk("rsvwb_stall_b", 16'(stall), 16'd1);
        rsv_en = 1'b1; rsv_addr = 5'd0;
        addr_b = 5'd1;
        step();
        rsv_en = 1'b0;
        #1;
        chk("rsv_r0_nostall", 16'(stall), 16'd0);
    endtask

    task automatic test_reset_mid_run();
        wb_cond = 1'b1; wb_addr = 5'd4; wb_data = 16'h00AA;
        step();
        wb_cond = 1'b0;
        rsv_en = 1'b1; rsv_addr = 5'd4;
        step();
        rsv_en = 1'b0;
        addr_a = 5'd4; addr_b = 5'd0;
        step();
        chk("mid_pre_data", data_a, 16'h00AA);
        chk("mid_pre_stall", 16'(stall), 16'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_estado", 16'(estado), 16'd0);
        chk("mid_stall", 16'(stall), 16'd1);
        chk("mid_data_a", data_a, 16'h0000);
        chk("mid_ready", 16'(ready), 16'd0);
        wait_clear();
        step();
        chk("mid_r4_cleared", data_a, 16'h0000);
        chk("mid_r4_nostall", 16'(stall), 16'd0);
    endtask

    task automatic test_back_to_back();
        addr_a = '0; addr_b = '0;
        for (int i = 10; i < 14; i++) begin
            wb_cond = 1'b1; wb_addr = 5'(i); wb_data = 16'(16'hA000 + i);
            step();
        end
        wb_cond = 1'b0;
        for (int i = 10; i < 14; i++) begin
            addr_a = 5'(i); addr_b = 5'(23 - i);
            step();
            chk($sformatf("b2b_a_r%0d", i), data_a, 16'(16'hA000 + i));
            chk($sformatf("b2b_b_r%0d", 23 - i), data_b, 16'(16'hA000 + 23 - i));
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_write_read();
        test_same_cycle();
        test_hazard();
        test_rsv_wb_same();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
